// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cache line <-> 64-bit memory burst adaptor
// Write-back path compiled in only when CACHELINE_ADAPTOR_WRITE_EN is defined.
`timescale 1ns/1ps
module cacheline_adaptor #(
    parameter int line_width  = 256,
    parameter int burst_width = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [line_width-1:0]  line_i,
    output logic [line_width-1:0]  line_o,
    output logic                   resp_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [burst_width-1:0] burst_o,
    input  logic [burst_width-1:0] burst_i,
    input  logic                   resp_i
);

    localparam int beats = line_width / burst_width;
    localparam int cnt_w = $clog2(beats);
    localparam int off_w = $clog2(line_width / 8);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                              state_q, state_d;
    logic   [cnt_w-1:0]                  cnt_q;
    logic   [31:0]                       addr_q;
    logic   [beats-1:0][burst_width-1:0] line_q;
    logic                                accept;
    logic                                beat_en;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef CACHELINE_ADAPTOR_WRITE_EN
                if (write_i) begin
                    state_d = WRITE;
                    accept  = 1'b1;
                end else if (read_i) begin
                    state_d = READ;
                    accept  = 1'b1;
                end
`else
                if (read_i) begin
                    state_d = READ;
                    accept  = 1'b1;
                end
`endif
            end
            READ, WRITE: begin
                if (resp_i && cnt_q == last_beat) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat strobes only count inside a burst; IDLE/DONE strobes are dropped.
    assign beat_en = resp_i && (state_q == READ || state_q == WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q  <= '0;
                addr_q <= {address_i[31:off_w], {off_w{1'b0}}};
            end else if (beat_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Slices are overwritten in place, so line_o shows a mix mid-burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (state_q == READ && resp_i) begin
            line_q[cnt_q] <= burst_i;
        end
    end

    assign line_o    = line_q;
    assign address_o = addr_q;
    assign read_o    = (state_q == READ);
    assign resp_o    = (state_q == DONE);

`ifdef CACHELINE_ADAPTOR_WRITE_EN
    logic [beats-1:0][burst_width-1:0] wbuf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbuf_q <= '0;
        end else if (accept && write_i) begin
            wbuf_q <= line_i;
        end
    end

    assign write_o = (state_q == WRITE);
    assign burst_o = (state_q == WRITE) ? wbuf_q[cnt_q] : '0;

    logic unused_inputs;
    assign unused_inputs = ^address_i[off_w-1:0];
`else
    assign write_o = 1'b0;
    assign burst_o = '0;

    logic unused_inputs;
    assign unused_inputs = ^{write_i, line_i, address_i[off_w-1:0]};
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
// Write-path steps run only when CACHELINE_ADAPTOR_WRITE_EN is defined.
`timescale 1ns/1ps
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int checks = 0;
    int errors = 0;

    cacheline_adaptor #(.line_width(256), .burst_width(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_read(input string tag, input logic [31:0] addr, input logic [255:0] line,
                            input int stall_at, input int stall_n, input int exp_resp,
                            input logic wr);
        int   cyc;
        int   beat;
        int   stalls;
        int   resp_cyc;
        logic seen_wr;
        address_i = addr;
        read_i    = 1'b1;
        write_i   = wr;
        line_i    = '1;
        tick;
        cyc = 1;
        chk({tag, ":read_o"}, read_o, 1);
        chk({tag, ":write_o"}, write_o, 0);
        chk({tag, ":address_o"}, address_o, {addr[31:5], 5'b0});
        chk({tag, ":burst_o"}, burst_o, 0);
        address_i = ~addr;
        beat      = 0;
        stalls    = stall_n;
        resp_cyc  = -1;
        seen_wr   = 1'b0;
        while (cyc < 30 && resp_cyc < 0) begin
            if (beat < 4 && beat == stall_at && stalls > 0) begin
                resp_i = 1'b0;
                stalls--;
            end else if (beat < 4) begin
                resp_i  = 1'b1;
                burst_i = line[beat*64 +: 64];
                beat++;
            end else begin
                resp_i = 1'b0;
            end
            tick;
            cyc++;
            if (write_o) seen_wr = 1'b1;
            if (resp_o) resp_cyc = cyc;
        end
        resp_i = 1'b0;
        chk({tag, ":resp_cycle"}, resp_cyc, exp_resp);
        chk({tag, ":line_o"}, line_o, line);
        chk({tag, ":address_hold"}, address_o, {addr[31:5], 5'b0});
        chk({tag, ":read_o_done"}, read_o, 0);
        chk({tag, ":write_o_never"}, seen_wr, 0);
        read_i    = 1'b0;
        write_i   = 1'b0;
        address_i = '0;
        tick;
        chk({tag, ":resp_pulse"}, resp_o, 0);
        chk({tag, ":idle_read_o"}, read_o, 0);
        chk({tag, ":line_hold"}, line_o, line);
    endtask

`ifdef CACHELINE_ADAPTOR_WRITE_EN
    task automatic run_write(input string tag, input logic [31:0] addr, input logic [255:0] line,
                             input logic rd);
        address_i = addr;
        write_i   = 1'b1;
        read_i    = rd;
        line_i    = line;
        tick;
        chk({tag, ":write_o"}, write_o, 1);
        chk({tag, ":read_o"}, read_o, 0);
        chk({tag, ":address_o"}, address_o, {addr[31:5], 5'b0});
        line_i    = ~line;
        address_i = ~addr;
        for (int k = 0; k < 4; k++) begin
            resp_i = 1'b1;
            chk($sformatf("%s:burst_o[%0d]", tag, k), burst_o, line[k*64 +: 64]);
            tick;
        end
        resp_i = 1'b0;
        chk({tag, ":resp_o"}, resp_o, 1);
        chk({tag, ":write_o_done"}, write_o, 0);
        chk({tag, ":address_hold"}, address_o, {addr[31:5], 5'b0});
        write_i = 1'b0;
        read_i  = 1'b0;
        tick;
        chk({tag, ":resp_pulse"}, resp_o, 0);
    endtask
`endif

    localparam logic [255:0] line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] line_b = {64'hFEDC_BA98_7654_3210, 64'h8888_8888_8888_8888,
                                       64'h0123_4567_89AB_CDEF, 64'h9999_9999_9999_9999};

    initial begin
        int resp_count;
        rst       = 1'b1;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        line_i    = '0;
        burst_i   = '0;
        resp_i    = 1'b0;
        tick;
        tick;
        chk("reset:read_o", read_o, 0);
        chk("reset:write_o", write_o, 0);
        chk("reset:resp_o", resp_o, 0);
        chk("reset:address_o", address_o, 0);
        chk("reset:line_o", line_o, 0);
        chk("reset:burst_o", burst_o, 0);
        rst = 1'b0;
        tick;

        // Stray memory strobe while idle must be ignored.
        resp_i  = 1'b1;
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        tick;
        resp_i = 1'b0;
        chk("idle_strobe:resp_o", resp_o, 0);
        chk("idle_strobe:read_o", read_o, 0);
        chk("idle_strobe:line_o", line_o, 0);
        tick;

        run_read("read_nostall", 32'h0000_1234, line_a, 0, 0, 5, 1'b0);
        run_read("read_stall", 32'hABCD_EF3F, line_a, 2, 3, 8, 1'b0);

        // Reset in the middle of a read burst.
        address_i = 32'h0000_4000;
        read_i    = 1'b1;
        tick;
        resp_i  = 1'b1;
        burst_i = 64'h5555_5555_5555_5555;
        tick;
        burst_i = 64'h6666_6666_6666_6666;
        tick;
        resp_i = 1'b0;
        rst    = 1'b1;
        read_i = 1'b0;
        tick;
        chk("abort:read_o", read_o, 0);
        chk("abort:resp_o", resp_o, 0);
        chk("abort:address_o", address_o, 0);
        chk("abort:line_o", line_o, 0);
        chk("abort:write_o", write_o, 0);
        rst        = 1'b0;
        resp_count = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (resp_o) resp_count++;
        end
        chk("abort:no_resp", resp_count, 0);
        run_read("read_after_abort", 32'h0000_4008, line_b, 0, 0, 5, 1'b0);

`ifdef CACHELINE_ADAPTOR_WRITE_EN
        run_write("write", 32'h0000_2040,
                  {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b0);
        run_write("both_req", 32'h0000_3077, line_b, 1'b1);
`else
        run_read("both_req", 32'h0000_3077, line_b, 1, 1, 6, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
